sum_collector: RTL and testbench

Receive-side companion to the 8-bit adder: captures each registered 9-bit sum on the adder's result strobe and buffers it in a small FIFO. It presents results downstream on a valid/ready handshake. The adder has no backpressure, so this block decouples it from a stalling consumer. It reports overflow (dropped results) and counts carry-out results for the bench and status logic.

---
 rtl/sum_collector_pkg.sv | 16 +
 rtl/sum_fifo.sv | 63 ++++++
 rtl/sum_collector.sv | 83 ++++++++
 tb/tb_sum_collector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sum_collector_pkg.sv
// ============================================================================
// sum_collector_pkg : shared widths and result type for the sum collector
// Rev 1.0
// ============================================================================
`default_nettype none

package sum_collector_pkg;
   localparam int WIDTH_DEFAULT = 9;
   localparam int DEPTH_DEFAULT = 4;
   localparam int DROP_CNT_W    = 8;
   localparam int CARRY_CNT_W   = 16;

   typedef logic [WIDTH_DEFAULT-1:0] sum_t;
endpackage

`default_nettype wire

// File: rtl/sum_fifo.sv
// ============================================================================
// sum_fifo : power-of-two FIFO with registered level and head read
// Rev 1.0
// ============================================================================
`default_nettype none

module sum_fifo
   import sum_collector_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;

   always_comb begin
      level_d = level_q;
      if (push_i && !pop_i)
         level_d = level_q + LW'(1);
      else if (!push_i && pop_i)
         level_d = level_q - LW'(1);
   end

   // Storage is cleared on reset so the head reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_i)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
endmodule

`default_nettype wire

// File: rtl/sum_collector.sv
// ============================================================================
// sum_collector : buffers adder results, valid/ready out, drop/carry stats
// Rev 1.0
// ============================================================================
`default_nettype none

module sum_collector
   import sum_collector_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_sum,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [DROP_CNT_W-1:0]    drop_cnt,
   output logic [CARRY_CNT_W-1:0]   carry_cnt,
   input  logic                     ovf_clr
);
   logic w_push, w_pop, w_drop, w_full, w_empty;
   logic                   overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CARRY_CNT_W-1:0] carry_cnt_q, carry_cnt_d;

   // A pop on a full FIFO frees the slot this same push lands in.
   assign w_pop  = out_valid & out_ready;
   assign w_push = in_valid & (~w_full | w_pop);
   assign w_drop = in_valid & ~w_push;

   sum_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (in_sum),
      .rdata_o (out_data),
      .level_o (level),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign out_valid = ~w_empty;

   always_comb begin
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      carry_cnt_d = carry_cnt_q;
      if (ovf_clr) begin
         overflow_d = w_drop;
         drop_cnt_d = w_drop ? DROP_CNT_W'(1) : '0;
      end else if (w_drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
      if (w_push && in_sum[WIDTH-1])
         carry_cnt_d = carry_cnt_q + CARRY_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         carry_cnt_q <= '0;
      end else begin
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign carry_cnt = carry_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_sum_collector.sv
// ============================================================================
// tb_sum_collector : directed self-checking bench for sum_collector
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sum_collector;
   import sum_collector_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  in_sum;
   logic        in_valid;
   logic [8:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic [15:0] carry_cnt;
   logic        ovf_clr;

   int n_total = 0;
   int n_bad   = 0;

   sum_collector #(.DEPTH(4), .WIDTH(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_sum    (in_sum),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .carry_cnt (carry_cnt),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [8:0] v);
      in_valid = 1'b1;
      in_sum   = v;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_sum = '0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check_eq("rst_valid", 32'(out_valid), 0);
      check_eq("rst_level", 32'(level), 0);
      check_eq("rst_ovf", 32'(overflow), 0);
      check_eq("rst_drop", 32'(drop_cnt), 0);
      check_eq("rst_carry", 32'(carry_cnt), 0);
      check_eq("rst_data", 32'(out_data), 0);

      // single result, 1-cycle latency, then pop
      push_one(9'h1FE);
      check_eq("one_valid", 32'(out_valid), 1);
      check_eq("one_data", 32'(out_data), 32'h1FE);
      check_eq("one_level", 32'(level), 1);
      check_eq("one_carry", 32'(carry_cnt), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("pop_level", 32'(level), 0);
      check_eq("pop_valid", 32'(out_valid), 0);

      // fill past full with no consumer
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1; in_sum = 9'(i);
         tick();
      end
      in_valid = 1'b0;
      check_eq("full_level", 32'(level), 4);
      check_eq("full_ovf", 32'(overflow), 1);
      check_eq("full_drop", 32'(drop_cnt), 1);
      check_eq("full_carry", 32'(carry_cnt), 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check_eq($sformatf("drain%0d", i), 32'(out_data), 32'(i));
         tick();
      end
      out_ready = 1'b0;
      check_eq("drain_level", 32'(level), 0);

      // push into full while popping is accepted
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check_eq("clr_ovf", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) push_one(9'h010 + 9'(i));
      out_ready = 1'b1; in_valid = 1'b1; in_sum = 9'h0AA;
      tick();
      in_valid = 1'b0;
      check_eq("fp_level", 32'(level), 4);
      check_eq("fp_ovf", 32'(overflow), 0);
      check_eq("fp_drop", 32'(drop_cnt), 0);
      for (int i = 1; i <= 3; i++) begin
         check_eq($sformatf("fp_out%0d", i), 32'(out_data), 32'h010 + 32'(i));
         tick();
      end
      check_eq("fp_last", 32'(out_data), 32'h0AA);
      tick();
      out_ready = 1'b0;
      check_eq("fp_empty", 32'(out_valid), 0);

      // saturating drops, clear interactions; dropped carries not counted
      for (int i = 0; i < 4; i++) push_one(9'h100 + 9'(i));
      check_eq("sat_carry_pre", 32'(carry_cnt), 5);
      in_valid = 1'b1; in_sum = 9'h1FF;
      repeat (300) tick();
      check_eq("sat_drop", 32'(drop_cnt), 255);
      check_eq("sat_ovf", 32'(overflow), 1);
      check_eq("sat_carry", 32'(carry_cnt), 5);
      ovf_clr = 1'b1;
      tick();
      check_eq("clrdrop_ovf", 32'(overflow), 1);
      check_eq("clrdrop_cnt", 32'(drop_cnt), 1);
      in_valid = 1'b0;
      tick();
      ovf_clr = 1'b0;
      check_eq("clr_ovf2", 32'(overflow), 0);
      check_eq("clr_cnt2", 32'(drop_cnt), 0);
      check_eq("clr_level", 32'(level), 4);
      check_eq("clr_carry", 32'(carry_cnt), 5);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("sat_out%0d", i), 32'(out_data), 32'h100 + 32'(i));
         tick();
      end
      check_eq("sat_empty", 32'(level), 0);

      // streaming with pointer wrap, zero-bubble
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_sum = 9'h020 + 9'(i);
         tick();
         check_eq($sformatf("str_out%0d", i), 32'(out_data), 32'h020 + 32'(i));
         check_eq($sformatf("str_lvl%0d", i), 32'(level), 1);
      end
      in_valid = 1'b0;
      tick();
      check_eq("str_end", 32'(level), 0);
      out_ready = 1'b0;

      // mid-operation reset
      for (int i = 0; i < 3; i++) push_one(9'h1C0 + 9'(i));
      check_eq("mr_level3", 32'(level), 3);
      check_eq("mr_carry8", 32'(carry_cnt), 8);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("mr_level", 32'(level), 0);
      check_eq("mr_valid", 32'(out_valid), 0);
      check_eq("mr_carry", 32'(carry_cnt), 0);
      check_eq("mr_drop", 32'(drop_cnt), 0);
      check_eq("mr_data", 32'(out_data), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
